// File: rtl/relax_osc_freq_meter_if.sv
// Frequency-meter control/result bundle between the tile and the meter core.
// master drives the request side, slave is the meter.
interface relax_osc_freq_meter_if #(
  parameter int CNT_W = 16
);
  logic             ena;
  logic             osc_in;
  logic             start;
  logic             continuous;
  logic [1:0]       gate_sel;
  logic [CNT_W-1:0] count_out;
  logic             valid;
  logic             overflow;
  logic             busy;

  modport master (
    output ena, osc_in, start, continuous, gate_sel,
    input  count_out, valid, overflow, busy
  );

  modport slave (
    input  ena, osc_in, start, continuous, gate_sel,
    output count_out, valid, overflow, busy
  );
endinterface

// File: rtl/relax_osc_freq_meter.sv
// Relaxation-oscillator frequency meter: sync, edge count over a gate window.
// Optional deglitch filter after the synchroniser: define OSC_DEGLITCH_EN.
module relax_osc_freq_meter #(
  parameter int CNT_W       = 16,
  parameter int GATE_W      = 17,
  parameter int SYNC_STAGES = 2
) (
  input logic clk,
  input logic rst_n,
  relax_osc_freq_meter_if.slave io
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GATE = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   hist_q, hist_d;
  logic [CNT_W-1:0]       acc_q, acc_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   sat_q, sat_d;
  logic                   ovf_q, ovf_d;
  logic                   valid_q, valid_d;
  logic                   busy_q, busy_d;
  logic [GATE_W-1:0]      tmr_q, tmr_d;
  logic [GATE_W-1:0]      gate_last;
  logic                   osc_s;
  logic                   osc_f;
  logic                   rise;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], io.osc_in};
  end

  assign osc_s = sync_q[SYNC_STAGES-1];

`ifdef OSC_DEGLITCH_EN
  logic filt_q, filt_d;
  logic dg_q, dg_d;

  // follow the input only after it has differed for two cycles in a row
  always_comb begin
    filt_d = filt_q;
    dg_d   = 1'b0;
    if (osc_s != filt_q) begin
      dg_d = 1'b1;
      if (dg_q) begin
        filt_d = osc_s;
        dg_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_q <= 1'b0;
      dg_q   <= 1'b0;
    end else begin
      filt_q <= filt_d;
      dg_q   <= dg_d;
    end
  end

  assign osc_f = filt_q;
`else
  assign osc_f = osc_s;
`endif

  assign hist_d = osc_f;
  assign rise   = osc_f & ~hist_q;

  always_comb begin
    unique case (io.gate_sel)
      2'd0:    gate_last = GATE_W'(1023);
      2'd1:    gate_last = GATE_W'(4095);
      2'd2:    gate_last = GATE_W'(16383);
      default: gate_last = GATE_W'(65535);
    endcase
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    sat_d   = sat_q;
    tmr_d   = tmr_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    valid_d = 1'b0;
    if (!io.ena) begin
      state_d = IDLE;
      acc_d   = '0;
      sat_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (io.start || io.continuous) begin
            state_d = GATE;
            acc_d   = '0;
            sat_d   = 1'b0;
            tmr_d   = gate_last;
          end
        end
        GATE: begin
          if (rise) begin
            if (&acc_q) sat_d = 1'b1;
            else        acc_d = acc_q + 1'b1;
          end
          // last window cycle: its edge is already folded into acc_d
          if (tmr_q == '0) begin
            state_d = DONE;
            cnt_d   = acc_d;
            ovf_d   = sat_d;
            valid_d = 1'b1;
          end else begin
            tmr_d = tmr_q - 1'b1;
          end
        end
        DONE: begin
          if (io.continuous) begin
            state_d = GATE;
            acc_d   = '0;
            sat_d   = 1'b0;
            tmr_d   = gate_last;
          end else begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_d == GATE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sync_q  <= '0;
      hist_q  <= 1'b0;
      acc_q   <= '0;
      sat_q   <= 1'b0;
      tmr_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      hist_q  <= hist_d;
      acc_q   <= acc_d;
      sat_q   <= sat_d;
      tmr_q   <= tmr_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign io.count_out = cnt_q;
  assign io.overflow  = ovf_q;
  assign io.valid     = valid_q;
  assign io.busy      = busy_q;

endmodule

// File: tb/tb_relax_osc_freq_meter.sv
// Bench for relax_osc_freq_meter: wide (16b) and narrow (8b) instances
// driven in parallel, checked against a periodic-waveform edge model.
module tb_relax_osc_freq_meter;
  localparam int NW = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic       osc = 1'b0;
  logic       start = 1'b0;
  logic       cont = 1'b0;
  logic [1:0] gsel = 2'd0;

  int vectors = 0;
  int miscompares = 0;
  int osc_per = 0;
  int osc_hi = 0;
  int ph = 0;
  int last_w = 0, last_ow = 0;
  int last_n = 0, last_on = 0;

  always #5 clk = ~clk;

  relax_osc_freq_meter_if #(.CNT_W(16)) wi ();
  relax_osc_freq_meter_if #(.CNT_W(NW)) ni ();

  assign wi.ena = ena;
  assign wi.osc_in = osc;
  assign wi.start = start;
  assign wi.continuous = cont;
  assign wi.gate_sel = gsel;
  assign ni.ena = ena;
  assign ni.osc_in = osc;
  assign ni.start = start;
  assign ni.continuous = cont;
  assign ni.gate_sel = gsel;

  relax_osc_freq_meter #(.CNT_W(16)) dut_w (
    .clk(clk), .rst_n(rst_n), .io(wi.slave)
  );
  relax_osc_freq_meter #(.CNT_W(NW)) dut_n (
    .clk(clk), .rst_n(rst_n), .io(ni.slave)
  );

  initial forever begin
    @(posedge clk);
    #1;
    if (osc_per == 0) begin
      osc = 1'b0;
      ph = 0;
    end else begin
      ph = (ph + 1) % osc_per;
      osc = (ph < osc_hi);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void model(input int gs, input int w,
                                output int c, output int o);
    int e, mx;
    e = (osc_per == 0) ? 0 : (1024 << (2 * gs)) / osc_per;
`ifdef OSC_DEGLITCH_EN
    if (osc_per != 0 && (osc_hi < 2 || osc_per - osc_hi < 2)) e = 0;
`endif
    mx = (1 << w) - 1;
    c = (e > mx) ? mx : e;
    o = (e > mx) ? 1 : 0;
  endfunction

  task automatic set_osc(input int per, input int hi);
    osc_per = per;
    osc_hi = hi;
    repeat (24) tick();
  endtask

  task automatic wait_valid(input int bound, output int n);
    n = 0;
    while (!wi.valid && n < bound) begin
      tick();
      n++;
    end
    if (!wi.valid) chk("valid_timeout", 0, 1);
  endtask

  task automatic run_meas(input int gs);
    int glen, nb, got, i, ew, eow, en, eon;
    glen = 1024 << (2 * gs);
    model(gs, 16, ew, eow);
    model(gs, NW, en, eon);
    gsel = 2'(gs);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_arm", wi.busy, 1);
    nb = 0;
    got = 0;
    i = 0;
    while (!got && i < glen + 8) begin
      if (wi.valid) begin
        got = 1;
      end else begin
        if (wi.busy) nb++;
        if (i == glen / 2) chk("hold_cnt", wi.count_out, last_w);
        tick();
        i++;
      end
    end
    chk("valid_seen", got, 1);
    chk("gate_len", nb, glen);
    chk("cnt_w", wi.count_out, ew);
    chk("ovf_w", wi.overflow, eow);
    chk("valid_n", ni.valid, 1);
    chk("cnt_n", ni.count_out, en);
    chk("ovf_n", ni.overflow, eon);
    last_w = ew; last_ow = eow;
    last_n = en; last_on = eon;
    tick();
    chk("valid_1cyc", wi.valid, 0);
    chk("busy_idle", wi.busy, 0);
  endtask

  initial begin
    int n, nv, per, hi, gs, ew, eow, en, eon;
    repeat (3) tick();
    chk("rst_cnt", wi.count_out, 0);
    chk("rst_valid", wi.valid, 0);
    chk("rst_busy", wi.busy, 0);
    chk("rst_ovf", wi.overflow, 0);
    rst_n = 1'b1;
    ena = 1'b1;

    set_osc(8, 4);
    run_meas(0);

    set_osc(2, 1);
    run_meas(0);

    set_osc(0, 0);
    run_meas(0);

    // continuous mode, gate 4096
    set_osc(8, 4);
    model(1, 16, ew, eow);
    model(1, NW, en, eon);
    gsel = 2'd1;
    cont = 1'b1;
    wait_valid(4200, n);
    chk("cont_cnt0", wi.count_out, ew);
    for (int k = 0; k < 2; k++) begin
      tick();
      wait_valid(4200, n);
      chk("cont_period", n + 1, 4097);
      chk("cont_cnt_w", wi.count_out, ew);
      chk("cont_cnt_n", ni.count_out, en);
      chk("cont_ovf_n", ni.overflow, eon);
    end
    tick();
    cont = 1'b0;
    wait_valid(4200, n);
    chk("cont_last", n + 1, 4097);
    last_w = ew; last_ow = eow;
    last_n = en; last_on = eon;
    tick();
    nv = 0;
    for (int k = 0; k < 50; k++) begin
      if (wi.valid || wi.busy) nv++;
      tick();
    end
    chk("cont_stop", nv, 0);

    // ena drop mid-window
    gsel = 2'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (499) tick();
    ena = 1'b0;
    tick();
    chk("abort_busy", wi.busy, 0);
    ena = 1'b1;
    nv = 0;
    for (int k = 0; k < 1100; k++) begin
      if (wi.valid) nv++;
      tick();
    end
    chk("abort_novalid", nv, 0);
    chk("abort_hold", wi.count_out, last_w);
    run_meas(0);

    // reset mid-window
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (300) tick();
    rst_n = 1'b0;
    #1;
    chk("mrst_cnt_w", wi.count_out, 0);
    chk("mrst_cnt_n", ni.count_out, 0);
    chk("mrst_busy", wi.busy, 0);
    chk("mrst_ovf_n", ni.overflow, 0);
    repeat (3) tick();
    rst_n = 1'b1;
    nv = 0;
    for (int k = 0; k < 1100; k++) begin
      if (wi.valid || wi.busy) nv++;
      tick();
    end
    chk("mrst_quiet", nv, 0);
    last_w = 0; last_ow = 0;
    last_n = 0; last_on = 0;

    for (int r = 0; r < 8; r++) begin
      per = 2 << $urandom_range(0, 5);
`ifdef OSC_DEGLITCH_EN
      hi = (per > 2) ? int'($urandom_range(2, per - 2)) : 1;
`else
      hi = int'($urandom_range(1, per - 1));
`endif
      gs = int'($urandom_range(0, 1));
      set_osc(per, hi);
      run_meas(gs);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/relax_osc_freq_meter.md
Name: relax_osc_freq_meter

Overview:
- Digital stage directly downstream of the relaxation oscillator macro.
- Takes the oscillator's asynchronous comparator output and synchronises it into the clk domain.
- Counts rising edges over a programmable gate window and publishes a latched frequency count with a one-cycle valid strobe.
- Drives the tile's digital outputs so the oscillator frequency can be read without an external counter.

Parameters:
- CNT_W, 16, edge-counter and result width; minimum 4.
- GATE_W, 17, gate-timer width; must hold 65535.
- SYNC_STAGES, 2, synchroniser flop count on osc_in; minimum 2.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- ena  input  1  tile enable; low aborts measurement.
- osc_in  input  1  asynchronous oscillator output.
- start  input  1  single-shot measurement request; level-sampled each cycle.
- continuous  input  1  1 = re-arm automatically after every result.
- gate_sel  input  2  gate length = 1024 << (2*gate_sel) cycles: 1024, 4096, 16384, 65536.
- count_out  output  CNT_W  last completed edge count.
- valid  output  1  one-cycle pulse when count_out updates.
- overflow  output  1  count for the current count_out saturated.
- busy  output  1  high while in GATE.

Behaviour:
- Reset (async assert, sync release): all of the following clear to 0: count_out, valid, overflow, busy, synchroniser flops, edge-history flop, accumulator, timer. FSM goes to IDLE.
- Sync: osc_in passes through SYNC_STAGES flops, then a history flop. An edge is sync=1 with hist=0. A transition on osc_in reaches the counter SYNC_STAGES+1 cycles later.
- FSM states:
  - IDLE:
    - ena=1 and (start or continuous) -> GATE.
    - On entry to GATE: accumulator cleared, timer loaded with gate_len-1, gate_sel captured.
  - GATE:
    - busy=1 every cycle.
    - An edge increments the accumulator, saturating at all-ones. Saturation sets an internal sat flag.
    - Timer decrements each cycle. On the cycle timer==0, that cycle's edge is still counted, then -> DONE.
    - Window length is exactly gate_len cycles.
  - DONE (one cycle):
    - count_out <= accumulator, overflow <= sat, valid=1.
    - Next state: GATE (re-armed as above) if continuous=1 and ena=1, else IDLE.
    - Edges in DONE are discarded: one dead cycle per measurement.
- In continuous mode valid recurs every gate_len+1 cycles.
- Edges seen in IDLE or DONE are discarded.
- start while busy is ignored.
- gate_sel changes during GATE have no effect until the next arm.
- ena=0 in any state: FSM -> IDLE next cycle, accumulator and sat cleared, no valid. count_out and overflow keep their last values.
- Reset mid-GATE: immediate clear per the reset rule; no valid.
- valid is never asserted for two consecutive cycles.
- Between results, count_out and overflow are stable.

Optional Feature:
- Macro: OSC_DEGLITCH_EN.
- Defined: a deglitch filter sits after the synchroniser. The filtered level changes only after the synchronised input has held the new value for 2 consecutive cycles. Pulses of 1 clk (high or low) are rejected. Latency adds 2 cycles.
- Undefined: the synchroniser output feeds the edge detector directly; there is no minimum pulse width beyond synchroniser sampling.

Test Plan:
- Reset, ena=1, osc_in period 8 clk (4 high/4 low), gate_sel=0, start pulse 1 cycle -> busy high 1024 cycles, then valid once, count_out=128, overflow=0.
- Same stimulus, gate_sel=1, continuous=1 -> valid every 4097 cycles, each count_out=512; drop continuous -> FSM returns to IDLE after the next valid.
- Build without OSC_DEGLITCH_EN and CNT_W=8; osc_in period 2 clk, gate_sel=0 -> count_out=255, overflow=1. Next run with osc_in held low -> count_out=0, overflow=0.
- Mid-GATE (cycle 500), drive ena=0 for 1 cycle -> busy=0 next cycle, no valid, count_out unchanged. Re-start -> fresh full count of 128.
- Assert rst_n=0 for 3 cycles mid-GATE -> all outputs 0 immediately. After release, no valid until a new start.
- With OSC_DEGLITCH_EN: osc_in period 2 clk -> count_out=0. Period 8 clk -> count_out=128.
